// File: rtl/eth_mdio_master.sv
// MDIO/SMI management master: Clause 22 and Clause 45 frames with an internally divided MDC,
// optional preamble, read turnaround checking and a valid/ready request/response interface.
module eth_mdio_master #(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_OE,
  input  logic        MDIO_I,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Cl45,
  input  logic [1:0]  Req_Op,
  input  logic [4:0]  Req_Phy_Addr,
  input  logic [4:0]  Req_Dev_Addr,
  input  logic [15:0] Req_Data,
  input  logic        Req_No_Pre,
  output logic        Busy,
  output logic        Rsp_Valid,
  output logic [15:0] Rsp_Data,
  output logic        Rsp_Err
);

  typedef enum logic [2:0] {IDLE, PRE, ST_OP, ADDR, TA, DATA, END} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_div, w_div_nxt;
  logic        r_half, w_half_nxt;
  logic [5:0]  r_bit, w_bit_nxt;
  logic [31:0] r_sreg, w_sreg_nxt;
  logic        r_read, w_read_nxt;
  logic        r_mdc, w_mdc_nxt;
  logic        r_mdo, w_mdo_nxt;
  logic        r_oe, w_oe_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [15:0] r_rsp_data, w_rsp_data_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic [15:0] r_rdata, w_rdata_nxt;
  logic        r_ta_err, w_ta_err_nxt;
  logic        r_mdi_s1, r_mdi_s2;
  logic        w_accept, w_illegal, w_half_end, w_emit;
  logic [31:0] w_frame;

  assign w_accept   = Req_Valid && r_ready;
  assign w_illegal  = !Req_Cl45 && ((Req_Op == 2'b00) || (Req_Op == 2'b11));
  assign w_half_end = (r_div == DIV_LAST);
  // Everything after the preamble, MSB first; TA is 10 for frames we drive.
  assign w_frame    = {(Req_Cl45 ? 2'b00 : 2'b01), Req_Op, Req_Phy_Addr, Req_Dev_Addr,
                       2'b10, Req_Data};

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_half_nxt      = r_half;
    w_bit_nxt       = r_bit;
    w_sreg_nxt      = r_sreg;
    w_read_nxt      = r_read;
    w_mdc_nxt       = r_mdc;
    w_mdo_nxt       = r_mdo;
    w_oe_nxt        = r_oe;
    w_ready_nxt     = r_ready;
    w_busy_nxt      = r_busy;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_rdata_nxt     = r_rdata;
    w_ta_err_nxt    = r_ta_err;
    w_emit          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_illegal) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_data_nxt  = 16'h0000;
        end else if (w_accept) begin
          w_read_nxt   = Req_Op[1];
          w_ready_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
          w_div_nxt    = 8'd0;
          w_half_nxt   = 1'b0;
          w_bit_nxt    = 6'd0;
          w_mdc_nxt    = 1'b0;
          w_oe_nxt     = 1'b1;
          w_rdata_nxt  = 16'h0000;
          w_ta_err_nxt = 1'b0;
          if (Req_No_Pre) begin
            w_state_nxt = ST_OP;
            w_mdo_nxt   = w_frame[31];
            w_sreg_nxt  = {w_frame[30:0], 1'b0};
          end else begin
            w_state_nxt = PRE;
            w_mdo_nxt   = 1'b1;
            w_sreg_nxt  = w_frame;
          end
        end else begin
          w_mdc_nxt = 1'b0;
        end
      end
      PRE, ST_OP, ADDR, TA, DATA, END: begin
        if (!w_half_end) begin
          w_div_nxt = r_div + 8'd1;
        end else if (!r_half) begin
          w_div_nxt  = 8'd0;
          w_half_nxt = 1'b1;
          w_mdc_nxt  = (r_state != END);
        end else begin
          // Bit boundary: r_mdi_s2 here is the sample from the last MDC-high cycle.
          w_div_nxt  = 8'd0;
          w_half_nxt = 1'b0;
          w_mdc_nxt  = 1'b0;
          w_bit_nxt  = r_bit + 6'd1;
          case (r_state)
            PRE: begin
              if (r_bit == PRE_LAST) begin
                w_state_nxt = ST_OP;
                w_bit_nxt   = 6'd0;
                w_emit      = 1'b1;
              end else begin
                w_mdo_nxt = 1'b1;
              end
            end
            ST_OP: begin
              w_emit = 1'b1;
              if (r_bit == 6'd3) begin
                w_state_nxt = ADDR;
                w_bit_nxt   = 6'd0;
              end else begin
                w_state_nxt = ST_OP;
              end
            end
            ADDR: begin
              w_emit = 1'b1;
              if (r_bit == 6'd9) begin
                w_state_nxt = TA;
                w_bit_nxt   = 6'd0;
                w_oe_nxt    = !r_read;
              end else begin
                w_state_nxt = ADDR;
              end
            end
            TA: begin
              w_emit = 1'b1;
              if (r_bit == 6'd1) begin
                w_state_nxt  = DATA;
                w_bit_nxt    = 6'd0;
                w_ta_err_nxt = r_read && r_mdi_s2;
              end else begin
                w_state_nxt = TA;
              end
            end
            DATA: begin
              if (r_read) begin
                w_rdata_nxt = {r_rdata[14:0], r_mdi_s2};
              end else begin
                w_rdata_nxt = r_rdata;
              end
              if (r_bit == 6'd15) begin
                w_state_nxt = END;
                w_bit_nxt   = 6'd0;
                w_oe_nxt    = 1'b0;
                w_mdo_nxt   = 1'b0;
              end else begin
                w_emit = 1'b1;
              end
            end
            END: begin
              w_state_nxt     = IDLE;
              w_bit_nxt       = 6'd0;
              w_busy_nxt      = 1'b0;
              w_ready_nxt     = 1'b1;
              w_rsp_valid_nxt = 1'b1;
              w_rsp_data_nxt  = r_read ? r_rdata : 16'h0000;
              w_rsp_err_nxt   = r_read && r_ta_err;
            end
            default: w_state_nxt = IDLE;
          endcase
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_emit) begin
      w_mdo_nxt  = w_oe_nxt && r_sreg[31];
      w_sreg_nxt = {r_sreg[30:0], 1'b0};
    end else begin
      w_sreg_nxt = w_sreg_nxt;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_div       <= 8'd0;
      r_half      <= 1'b0;
      r_bit       <= 6'd0;
      r_sreg      <= 32'd0;
      r_read      <= 1'b0;
      r_mdc       <= 1'b0;
      r_mdo       <= 1'b0;
      r_oe        <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 16'h0000;
      r_ta_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_half      <= w_half_nxt;
      r_bit       <= w_bit_nxt;
      r_sreg      <= w_sreg_nxt;
      r_read      <= w_read_nxt;
      r_mdc       <= w_mdc_nxt;
      r_mdo       <= w_mdo_nxt;
      r_oe        <= w_oe_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ta_err    <= w_ta_err_nxt;
    end
  end

  // Two-flop synchroniser for the asynchronous MDIO input.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_mdi_s1 <= 1'b1;
      r_mdi_s2 <= 1'b1;
    end else begin
      r_mdi_s1 <= MDIO_I;
      r_mdi_s2 <= r_mdi_s1;
    end
  end

  assign MDC       = r_mdc;
  assign MDIO_O    = r_mdo;
  assign MDIO_OE   = r_oe;
  assign Req_Ready = r_ready;
  assign Busy      = r_busy;
  assign Rsp_Valid = r_rsp_valid;
  assign Rsp_Data  = r_rsp_data;
  assign Rsp_Err   = r_rsp_err;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Scoreboard bench for eth_mdio_master: a PHY model answers reads on MDC falls and every
// MDC rise is captured so whole frames can be compared against the expected bit stream.
module tb_eth_mdio_master;

  localparam int C  = 3;
  localparam int PL = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MDC, MDIO_O, MDIO_OE;
  logic        mdio_i = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic        Req_Cl45 = 1'b0;
  logic [1:0]  Req_Op = 2'b00;
  logic [4:0]  Req_Phy_Addr = 5'd0;
  logic [4:0]  Req_Dev_Addr = 5'd0;
  logic [15:0] Req_Data = 16'h0000;
  logic        Req_No_Pre = 1'b0;
  logic        Busy, Rsp_Valid, Rsp_Err;
  logic [15:0] Rsp_Data;

  eth_mdio_master #(.CLK_DIV(C), .PRE_LEN(PL)) dut (
    .Clk(clk), .Rst_n(rst_n), .MDC(MDC), .MDIO_O(MDIO_O), .MDIO_OE(MDIO_OE),
    .MDIO_I(mdio_i), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Cl45(Req_Cl45),
    .Req_Op(Req_Op), .Req_Phy_Addr(Req_Phy_Addr), .Req_Dev_Addr(Req_Dev_Addr),
    .Req_Data(Req_Data), .Req_No_Pre(Req_No_Pre), .Busy(Busy), .Rsp_Valid(Rsp_Valid),
    .Rsp_Data(Rsp_Data), .Rsp_Err(Rsp_Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          n;
    logic [95:0] eo;
    logic [95:0] eoe;
    time         t_acc;
    int          base;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          rises = 0;
  logic [95:0] got_o = '0;
  logic [95:0] got_oe = '0;
  int          phy_base = 0;
  int          phy_pre = PL;
  logic        phy_read = 1'b0;
  logic [15:0] phy_data = 16'h0000;
  logic        phy_ta1 = 1'b0;

  // Capture of each transmitted bit as seen by the PHY on MDC rise.
  always @(posedge MDC) begin
    rises  = rises + 1;
    got_o  = {got_o[94:0], MDIO_O};
    got_oe = {got_oe[94:0], MDIO_OE};
  end

  // PHY model: bit idx starts at the MDC fall after idx rises; the line idles high (pull-up).
  always @(negedge MDC) begin
    int idx;
    idx = rises - phy_base;
    if (phy_read && idx == phy_pre + 15) mdio_i = phy_ta1;
    else if (phy_read && idx >= phy_pre + 16 && idx < phy_pre + 32)
      mdio_i = phy_data[15 - (idx - phy_pre - 16)];
    else mdio_i = 1'b1;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic cl45, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] dev, input logic [15:0] data, input logic nopre,
                           input logic [15:0] rdv, input logic ta1, input logic push);
    exp_t        e;
    logic        legal, rd;
    int          pre, k;
    logic [95:0] mask;
    logic [31:0] fr;
    legal = cl45 || op == 2'b01 || op == 2'b10;
    rd    = legal && op[1];
    pre   = nopre ? 0 : PL;
    k = 0;
    while (!Req_Ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_req", Req_Ready, 1);
    phy_read = rd; phy_pre = pre; phy_data = rdv; phy_ta1 = ta1; phy_base = rises;
    Req_Cl45 = cl45; Req_Op = op; Req_Phy_Addr = phy; Req_Dev_Addr = dev;
    Req_Data = data; Req_No_Pre = nopre; Req_Valid = 1'b1;
    @(posedge clk);
    e.t_acc = $time;
    #1 Req_Valid = 1'b0;
    fr    = {(cl45 ? 2'b00 : 2'b01), op, phy, dev, 2'b10, data};
    e.n   = legal ? 32 + pre : 0;
    mask  = (96'd1 << e.n) - 96'd1;
    e.eo  = {64'd0, fr};
    if (pre > 0) e.eo = e.eo | (((96'd1 << pre) - 96'd1) << 32);
    e.eoe  = rd ? (mask & ~96'h3FFFF) : mask;
    e.data = rd ? rdv : 16'h0000;
    e.err  = rd ? ta1 : !legal;
    e.lat  = legal ? 1 + 2 * (e.n + 1) * C : 1;
    e.base = phy_base;
    if (push) sb.push_back(e);
    @(negedge clk);
    check("busy_t1", Busy, legal);
    check("ready_t1", Req_Ready, !legal);
  endtask

  task automatic wait_rsp();
    exp_t        e;
    int          k, lat;
    logic [95:0] mask;
    k = 0;
    while (!Rsp_Valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!Rsp_Valid) begin
      check("rsp_timeout", Rsp_Valid, 1);
    end else if (sb.size() == 0) begin
      check("rsp_unexpected", Rsp_Valid, 0);
    end else begin
      e   = sb.pop_front();
      lat = int'(($time - e.t_acc - 5) / 10) + 1;
      check("rsp_data", Rsp_Data, e.data);
      check("rsp_err", Rsp_Err, e.err);
      check("rsp_latency", lat, e.lat);
      check("mdc_rises", rises - e.base, e.n);
      check("ready_at_rsp", Req_Ready, 1);
      check("busy_at_rsp", Busy, 0);
      if (e.n > 0) begin
        mask = (96'd1 << e.n) - 96'd1;
        check("mdio_oe_bits", got_oe & mask, e.eoe);
        check("mdio_o_bits", got_o & e.eoe, e.eo & e.eoe);
      end
      @(negedge clk);
      check("rsp_one_cycle", Rsp_Valid, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_mdc", MDC, 0);
    check("rst_mdio_o", MDIO_O, 0);
    check("rst_mdio_oe", MDIO_OE, 0);
    check("rst_ready", Req_Ready, 1);
    check("rst_busy", Busy, 0);
    check("rst_rsp_valid", Rsp_Valid, 0);
    check("rst_rsp_data", Rsp_Data, 0);
    check("rst_rsp_err", Rsp_Err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_req(1'b0, 2'b01, 5'h01, 5'h00, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1); wait_rsp();
    start_req(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b1); wait_rsp();
    start_req(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b1); wait_rsp();
    start_req(1'b1, 2'b00, 5'h05, 5'h1E, 16'h8001, 1'b0, 16'h0000, 1'b0, 1'b1); wait_rsp();
    start_req(1'b1, 2'b11, 5'h05, 5'h1E, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b1); wait_rsp();
    start_req(1'b1, 2'b01, 5'h12, 5'h07, 16'hC3A5, 1'b1, 16'h0000, 1'b0, 1'b1); wait_rsp();
    start_req(1'b0, 2'b10, 5'h07, 5'h11, 16'h0000, 1'b1, 16'hA5C3, 1'b0, 1'b1); wait_rsp();
    start_req(1'b0, 2'b11, 5'h07, 5'h11, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1); wait_rsp();
    start_req(1'b0, 2'b00, 5'h02, 5'h04, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1); wait_rsp();

    // Reset while the PHY address field is on the wire; the frame must vanish silently.
    start_req(1'b0, 2'b01, 5'h0A, 5'h15, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0);
    k = 0;
    while ((rises - phy_base) < PL + 6 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reached_addr", MDC, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mdc", MDC, 0);
    check("abort_oe", MDIO_OE, 0);
    check("abort_busy", Busy, 0);
    check("abort_rsp_valid", Rsp_Valid, 0);
    check("abort_ready", Req_Ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (Rsp_Valid) check("no_rsp_after_abort", Rsp_Valid, 0);
    end
    check("ready_after_abort", Req_Ready, 1);
    start_req(1'b0, 2'b01, 5'h0A, 5'h15, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1); wait_rsp();
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
